// File: rtl/target_pool.sv
// Pool of NUM_TARGETS target slots plus an interval spawn scheduler, clocked by the 100 Hz game tick.
// Optional macro TARGET_SPEEDUP_EN: flying speed rises by one every 16 kills (max +3).
module target_pool #(
   parameter int unsigned NUM_TARGETS    = 4,
   parameter int unsigned LANE_BITS      = 3,
   parameter int unsigned LANE_BASE      = 48,
   parameter int unsigned LANE_PITCH     = 40,
   parameter int unsigned INIT_X_OFFSET  = 674,
   parameter int unsigned VX_FLY         = 3,
   parameter int unsigned VX_DIE         = 2,
   parameter int unsigned Y_FLOOR        = 400,
   parameter int unsigned SPAWN_INTERVAL = 64
) (
   input  logic                       clk_100Hz,
   input  logic                       rst,
   input  logic                       start,
   input  logic [LANE_BITS-1:0]       din,
   input  logic [NUM_TARGETS-1:0]     shot,
   output logic [10*NUM_TARGETS-1:0]  x_flat,
   output logic [9*NUM_TARGETS-1:0]   y_flat,
   output logic [2*NUM_TARGETS-1:0]   state_flat,
   output logic [2*NUM_TARGETS-1:0]   anim_flat,
   output logic [NUM_TARGETS-1:0]     kill,
   output logic [15:0]                kill_count,
   output logic [1:0]                 speed_level
);
   localparam int unsigned CNT_W = $clog2(SPAWN_INTERVAL);
   localparam int unsigned HIT_W = $clog2(NUM_TARGETS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_INTERVAL - 1);
   localparam logic [9:0] XO_INIT  = 10'(INIT_X_OFFSET);
   localparam logic [9:0] X_BIAS   = 10'd34;
   localparam logic [9:0] VDIE     = 10'(VX_DIE);
   localparam logic [8:0] YFLOOR   = 9'(Y_FLOOR);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FLY = 2'd1, ST_DIE = 2'd2} slot_st_e;

   slot_st_e                r_state [NUM_TARGETS];
   logic [9:0]              r_xo    [NUM_TARGETS];
   logic [8:0]              r_y     [NUM_TARGETS];
   logic [4:0]              r_anim  [NUM_TARGETS];
   logic [7:0]              r_vy    [NUM_TARGETS];
   logic                    r_running;
   logic [CNT_W-1:0]        r_cnt;
   logic [NUM_TARGETS-1:0]  r_kill;
   logic [15:0]             r_kill_count;
   logic [1:0]              r_speed;

   slot_st_e                w_state_nxt [NUM_TARGETS];
   logic [9:0]              w_xo_nxt    [NUM_TARGETS];
   logic [8:0]              w_y_nxt     [NUM_TARGETS];
   logic [4:0]              w_anim_nxt  [NUM_TARGETS];
   logic [7:0]              w_vy_nxt    [NUM_TARGETS];
   logic                    w_running_nxt;
   logic [CNT_W-1:0]        w_cnt_nxt;
   logic [NUM_TARGETS-1:0]  w_kill_nxt;
   logic [15:0]             w_kill_count_nxt;
   logic [1:0]              w_speed_nxt;
   logic [NUM_TARGETS-1:0]  w_idle;
   logic [NUM_TARGETS-1:0]  w_spawn_oh;
   logic                    w_spawn;
   logic [HIT_W-1:0]        w_hits;
   logic [16:0]             w_kc_sum;
   logic [9:0]              w_vfly;
   logic [8:0]              w_lane_y;

   assign w_vfly   = 10'(VX_FLY) + 10'(r_speed);
   assign w_lane_y = 9'(LANE_BASE + LANE_PITCH * 32'(din));

   // State register: rst wins over everything, including slots in flight or falling.
   always_ff @(posedge clk_100Hz) begin
      if (rst) begin
         r_running    <= 1'b0;
         r_cnt        <= '0;
         r_kill       <= '0;
         r_kill_count <= '0;
         r_speed      <= '0;
         for (int i = 0; i < int'(NUM_TARGETS); i++) begin
            r_state[i] <= ST_IDLE;
            r_xo[i]    <= XO_INIT;
            r_y[i]     <= '0;
            r_anim[i]  <= '0;
            r_vy[i]    <= '0;
         end
      end else begin
         r_running    <= w_running_nxt;
         r_cnt        <= w_cnt_nxt;
         r_kill       <= w_kill_nxt;
         r_kill_count <= w_kill_count_nxt;
         r_speed      <= w_speed_nxt;
         for (int i = 0; i < int'(NUM_TARGETS); i++) begin
            r_state[i] <= w_state_nxt[i];
            r_xo[i]    <= w_xo_nxt[i];
            r_y[i]     <= w_y_nxt[i];
            r_anim[i]  <= w_anim_nxt[i];
            r_vy[i]    <= w_vy_nxt[i];
         end
      end
   end

   // Next state: scheduler, per-slot motion, kill accounting.
   always_comb begin
      w_running_nxt = r_running;
      w_cnt_nxt     = r_cnt;
      w_kill_nxt    = '0;
      w_speed_nxt   = r_speed;
      w_hits        = '0;
      w_spawn       = 1'b0;
      w_idle        = '0;
      for (int i = 0; i < int'(NUM_TARGETS); i++) begin
         w_idle[i]      = (r_state[i] == ST_IDLE);
         w_state_nxt[i] = r_state[i];
         w_xo_nxt[i]    = r_xo[i];
         w_y_nxt[i]     = r_y[i];
         w_anim_nxt[i]  = r_anim[i];
         w_vy_nxt[i]    = r_vy[i];
      end
      // Lowest-index registered idle slot; same-edge retirees are not eligible.
      w_spawn_oh = w_idle & (~w_idle + NUM_TARGETS'(1));

      if (!r_running) begin
         if (start) begin
            w_running_nxt = 1'b1;
            w_cnt_nxt     = '0;
         end
      end else if (r_cnt == CNT_LAST) begin
         if (|w_idle) begin
            w_cnt_nxt = '0;
            w_spawn   = 1'b1;
         end
      end else begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end

      for (int i = 0; i < int'(NUM_TARGETS); i++) begin
         unique case (r_state[i])
            ST_FLY: begin
               if (r_xo[i] <= w_vfly) begin
                  w_state_nxt[i] = ST_IDLE;
               end else if (shot[i]) begin
                  w_state_nxt[i] = ST_DIE;
                  w_kill_nxt[i]  = 1'b1;
                  w_hits         = w_hits + HIT_W'(1);
               end else begin
                  w_xo_nxt[i]   = r_xo[i] - w_vfly;
                  w_anim_nxt[i] = r_anim[i] + 5'd1;
               end
            end
            ST_DIE: begin
               if (r_y[i] >= YFLOOR || r_xo[i] <= VDIE) begin
                  w_state_nxt[i] = ST_IDLE;
               end else begin
                  w_y_nxt[i]  = r_y[i] + 9'(r_vy[i] / 8'd10);
                  w_vy_nxt[i] = (r_vy[i] == 8'hFF) ? 8'hFF : r_vy[i] + 8'd1;
                  w_xo_nxt[i] = r_xo[i] - VDIE;
               end
            end
            default: ;
         endcase
         if (w_spawn && w_spawn_oh[i]) begin
            w_state_nxt[i] = ST_FLY;
            w_xo_nxt[i]    = XO_INIT;
            w_y_nxt[i]     = w_lane_y;
            w_anim_nxt[i]  = '0;
            w_vy_nxt[i]    = '0;
         end
      end

      w_kc_sum         = 17'(r_kill_count) + 17'(w_hits);
      w_kill_count_nxt = w_kc_sum[16] ? 16'hFFFF : w_kc_sum[15:0];
`ifdef TARGET_SPEEDUP_EN
      // At most NUM_TARGETS<=8 kills per tick, so one multiple of 16 is crossed at most.
      if (w_kill_count_nxt[15:4] != r_kill_count[15:4] && r_speed != 2'd3)
         w_speed_nxt = r_speed + 2'd1;
`else
      w_speed_nxt = 2'd0;
`endif
   end

   // Outputs decoded straight from registered state.
   always_comb begin
      x_flat      = '0;
      y_flat      = '0;
      state_flat  = '0;
      anim_flat   = '0;
      for (int i = 0; i < int'(NUM_TARGETS); i++) begin
         x_flat[10*i +: 10]   = r_xo[i] - X_BIAS;
         y_flat[9*i +: 9]     = r_y[i];
         state_flat[2*i +: 2] = r_state[i];
         if (r_state[i] == ST_DIE)
            anim_flat[2*i +: 2] = 2'd3;
         else if (r_anim[i][4:3] == 2'd3)
            anim_flat[2*i +: 2] = 2'd1;
         else
            anim_flat[2*i +: 2] = r_anim[i][4:3];
      end
      kill        = r_kill;
      kill_count  = r_kill_count;
      speed_level = r_speed;
   end

endmodule

// File: tb/tb_target_pool.sv
// Bench for target_pool: directed vector table, reset sequences, random play against a reference model.
`timescale 1ns/1ps
module tb_target_pool;
   localparam int NT = 4;

   logic        clk_100Hz = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  din = '0;
   logic [3:0]  shot = '0;
   logic [39:0] x_flat;
   logic [35:0] y_flat;
   logic [7:0]  state_flat;
   logic [7:0]  anim_flat;
   logic [3:0]  kill;
   logic [15:0] kill_count;
   logic [1:0]  speed_level;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_100Hz = ~clk_100Hz;

   target_pool dut (
      .clk_100Hz   (clk_100Hz),
      .rst         (rst),
      .start       (start),
      .din         (din),
      .shot        (shot),
      .x_flat      (x_flat),
      .y_flat      (y_flat),
      .state_flat  (state_flat),
      .anim_flat   (anim_flat),
      .kill        (kill),
      .kill_count  (kill_count),
      .speed_level (speed_level)
   );

   // Reference model: slot states 0 idle, 1 flying, 2 dying; plain integer arithmetic.
   int         m_st [NT];
   int         m_xo [NT];
   int         m_y  [NT];
   int         m_ac [NT];
   int         m_vy [NT];
   bit         m_run;
   int         m_cnt;
   int         m_kc;
   logic [3:0] m_kill;

   function automatic int m_speed();
`ifdef TARGET_SPEEDUP_EN
      return (m_kc / 16 > 3) ? 3 : m_kc / 16;
`else
      return 0;
`endif
   endfunction

   function automatic int anim_of(int st, int ac);
      int seq [4] = '{0, 1, 2, 1};
      if (st == 2) return 3;
      return seq[(ac / 8) % 4];
   endfunction

   function automatic void model_step();
      int vfly;
      int sp;
      int hits;
      if (rst) begin
         for (int i = 0; i < NT; i++) begin
            m_st[i] = 0; m_xo[i] = 674; m_y[i] = 0; m_ac[i] = 0; m_vy[i] = 0;
         end
         m_run = 0; m_cnt = 0; m_kc = 0; m_kill = '0;
         return;
      end
      vfly = 3 + m_speed();
      sp = -1;
      for (int i = 0; i < NT; i++) if (m_st[i] == 0 && sp < 0) sp = i;
      m_kill = '0;
      hits = 0;
      for (int i = 0; i < NT; i++) begin
         if (m_st[i] == 1) begin
            if (m_xo[i] <= vfly) m_st[i] = 0;
            else if (shot[i]) begin m_st[i] = 2; m_kill[i] = 1'b1; hits++; end
            else begin m_xo[i] -= vfly; m_ac[i] = (m_ac[i] + 1) % 32; end
         end else if (m_st[i] == 2) begin
            if (m_y[i] >= 400 || m_xo[i] <= 2) m_st[i] = 0;
            else begin
               m_y[i] += m_vy[i] / 10;
               m_vy[i] = (m_vy[i] + 1 > 255) ? 255 : m_vy[i] + 1;
               m_xo[i] -= 2;
            end
         end
      end
      if (!m_run) begin
         if (start) begin m_run = 1; m_cnt = 0; end
      end else if (m_cnt == 63) begin
         if (sp >= 0) begin
            m_cnt = 0;
            m_st[sp] = 1; m_xo[sp] = 674; m_y[sp] = 48 + 40 * int'(din); m_ac[sp] = 0; m_vy[sp] = 0;
         end
      end else begin
         m_cnt++;
      end
      m_kc = (m_kc + hits > 65535) ? 65535 : m_kc + hits;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_compare();
      logic [39:0] ex;
      logic [35:0] ey;
      logic [7:0]  es;
      logic [7:0]  ea;
      for (int i = 0; i < NT; i++) begin
         ex[10*i +: 10] = 10'((m_xo[i] - 34) & 1023);
         ey[9*i +: 9]   = 9'(m_y[i]);
         es[2*i +: 2]   = 2'(m_st[i]);
         ea[2*i +: 2]   = 2'(anim_of(m_st[i], m_ac[i]));
      end
      check("model_x", 64'(x_flat), 64'(ex));
      check("model_y", 64'(y_flat), 64'(ey));
      check("model_state", 64'(state_flat), 64'(es));
      check("model_anim", 64'(anim_flat), 64'(ea));
      check("model_kill", 64'(kill), 64'(m_kill));
      check("model_kill_count", 64'(kill_count), 64'(m_kc));
      check("model_speed", 64'(speed_level), 64'(m_speed()));
   endtask

   // One game tick: inputs already driven; sample #1 after the edge.
   task automatic tick();
      @(posedge clk_100Hz);
      #1;
      model_step();
      model_compare();
   endtask

   typedef struct {
      int          edges;
      logic        start;
      logic [2:0]  din;
      logic [3:0]  shot;
      int          sl;
      bit          chk_slot;
      logic [7:0]  e_st;
      logic [9:0]  e_x;
      logic [8:0]  e_y;
      logic [1:0]  e_anim;
      logic [3:0]  e_kill;
      logic [15:0] e_kc;
   } vec_t;

   vec_t tbl [18];

   initial begin
      // Timeline from E0 (start edge): spawns at +64/128/192/256, slot0 exits +289, respawns +320.
      tbl[0]  = '{1,   1'b1, 3'd2, 4'h0, 0, 1'b1, 8'h00, 10'd640, 9'd0,   2'd0, 4'h0, 16'd0};
      tbl[1]  = '{63,  1'b0, 3'd2, 4'h0, 0, 1'b1, 8'h00, 10'd640, 9'd0,   2'd0, 4'h0, 16'd0};
      tbl[2]  = '{1,   1'b0, 3'd2, 4'h0, 0, 1'b1, 8'h01, 10'd640, 9'd128, 2'd0, 4'h0, 16'd0};
      tbl[3]  = '{8,   1'b0, 3'd0, 4'h0, 0, 1'b1, 8'h01, 10'd616, 9'd128, 2'd1, 4'h0, 16'd0};
      tbl[4]  = '{8,   1'b0, 3'd0, 4'h0, 0, 1'b1, 8'h01, 10'd592, 9'd128, 2'd2, 4'h0, 16'd0};
      tbl[5]  = '{8,   1'b0, 3'd0, 4'h0, 0, 1'b1, 8'h01, 10'd568, 9'd128, 2'd1, 4'h0, 16'd0};
      tbl[6]  = '{8,   1'b0, 3'd0, 4'h0, 0, 1'b1, 8'h01, 10'd544, 9'd128, 2'd0, 4'h0, 16'd0};
      tbl[7]  = '{192, 1'b0, 3'd0, 4'h0, 0, 1'b1, 8'h55, 10'd992, 9'd128, 2'd0, 4'h0, 16'd0};
      tbl[8]  = '{1,   1'b0, 3'd0, 4'h0, 0, 1'b0, 8'h54, 10'd0,   9'd0,   2'd0, 4'h0, 16'd0};
      tbl[9]  = '{31,  1'b0, 3'd5, 4'h0, 0, 1'b1, 8'h55, 10'd640, 9'd248, 2'd0, 4'h0, 16'd0};
      tbl[10] = '{1,   1'b0, 3'd0, 4'h3, 0, 1'b1, 8'h5A, 10'd640, 9'd248, 2'd3, 4'h3, 16'd2};
      tbl[11] = '{10,  1'b0, 3'd0, 4'h0, 0, 1'b1, 8'h5A, 10'd620, 9'd248, 2'd3, 4'h0, 16'd2};
      tbl[12] = '{1,   1'b0, 3'd0, 4'h0, 0, 1'b1, 8'h5A, 10'd618, 9'd249, 2'd3, 4'h0, 16'd2};
      tbl[13] = '{50,  1'b0, 3'd0, 4'h0, 0, 1'b1, 8'h52, 10'd518, 9'd404, 2'd3, 4'h0, 16'd2};
      tbl[14] = '{1,   1'b0, 3'd0, 4'h0, 0, 1'b0, 8'h50, 10'd0,   9'd0,   2'd0, 4'h0, 16'd2};
      tbl[15] = '{1,   1'b0, 3'd1, 4'h0, 0, 1'b1, 8'h51, 10'd640, 9'd88,  2'd0, 4'h0, 16'd2};
      tbl[16] = '{32,  1'b0, 3'd0, 4'h0, 2, 1'b1, 8'h51, 10'd992, 9'd48,  2'd0, 4'h0, 16'd2};
      tbl[17] = '{1,   1'b0, 3'd0, 4'h6, 0, 1'b0, 8'h41, 10'd0,   9'd0,   2'd0, 4'h0, 16'd2};

      // Power-on reset, checked after the first rst edge.
      rst = 1'b1;
      tick();
      check("rst_state", 64'(state_flat), 64'h0);
      check("rst_x", 64'(x_flat), 64'({4{10'd640}}));
      check("rst_y", 64'(y_flat), 64'h0);
      check("rst_kill", 64'(kill), 64'h0);
      check("rst_kill_count", 64'(kill_count), 64'h0);
      check("rst_speed", 64'(speed_level), 64'h0);
      tick();
      tick();
      rst = 1'b0;

      for (int r = 0; r < 18; r++) begin
         start = tbl[r].start;
         din   = tbl[r].din;
         shot  = tbl[r].shot;
         for (int e = 0; e < tbl[r].edges; e++) tick();
         start = 1'b0;
         shot  = '0;
         check($sformatf("row%0d_state", r), 64'(state_flat), 64'(tbl[r].e_st));
         check($sformatf("row%0d_kill", r), 64'(kill), 64'(tbl[r].e_kill));
         check($sformatf("row%0d_kill_count", r), 64'(kill_count), 64'(tbl[r].e_kc));
         if (tbl[r].chk_slot) begin
            check($sformatf("row%0d_x", r), 64'(x_flat[10*tbl[r].sl +: 10]), 64'(tbl[r].e_x));
            check($sformatf("row%0d_y", r), 64'(y_flat[9*tbl[r].sl +: 9]), 64'(tbl[r].e_y));
            check($sformatf("row%0d_anim", r), 64'(anim_flat[2*tbl[r].sl +: 2]), 64'(tbl[r].e_anim));
         end
      end

      // Mid-game reset with start held high: reset wins, game must not start.
      rst   = 1'b1;
      start = 1'b1;
      tick();
      check("midrst_state", 64'(state_flat), 64'h0);
      check("midrst_x", 64'(x_flat), 64'({4{10'd640}}));
      check("midrst_y", 64'(y_flat), 64'h0);
      check("midrst_kill_count", 64'(kill_count), 64'h0);
      tick();
      tick();
      rst   = 1'b0;
      start = 1'b0;
      repeat (70) tick();
      check("no_start_after_rst", 64'(state_flat), 64'h0);

      // Random play against the model.
      for (int c = 0; c < 4000; c++) begin
         rst   = ($urandom_range(0, 1499) == 0);
         start = ($urandom_range(0, 9) == 0);
         din   = 3'($urandom);
         shot  = ($urandom_range(0, 39) == 0) ? 4'($urandom) : 4'h0;
         tick();
      end
      rst   = 1'b0;
      start = 1'b0;
      shot  = '0;

`ifdef TARGET_SPEEDUP_EN
      check("speed_final", 64'(speed_level), 64'((m_kc / 16 > 3) ? 3 : m_kc / 16));
`else
      check("speed_final", 64'(speed_level), 64'h0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/target_pool.md
Name: target_pool

Overview:
- Parametrised successor to the single red-bird target FSM. Manages NUM_TARGETS independent target slots plus a spawn scheduler that releases idle slots into random lanes at a fixed interval.
- Reports per-slot position, state and animation frame to the renderer, and kill events/score to game control.
- Sits between the LFSR (din), collision detector (shot vector) and VGA sprite renderer; all logic runs in the 100 Hz game-tick domain.

Parameters:
- NUM_TARGETS, 4, number of slots (1..8)
- LANE_BITS, 3, lane index width; lanes = 2^LANE_BITS
- LANE_BASE, 48, y of lane 0
- LANE_PITCH, 40, y distance between lanes
- INIT_X_OFFSET, 674, x_offset loaded on spawn; x = x_offset - 34
- VX_FLY, 3, x decrement per tick while flying
- VX_DIE, 2, x decrement per tick while dying
- Y_FLOOR, 400, dying slot retires when y >= Y_FLOOR
- SPAWN_INTERVAL, 64, ticks between spawns (>=2)

Ports:
- clk_100Hz input 1 game tick clock
- rst input 1 synchronous active-high reset
- start input 1 game start request
- din input LANE_BITS random lane select
- shot input NUM_TARGETS per-slot hit from collision detector
- x_flat output 10*NUM_TARGETS slot i x at [10i+9:10i]
- y_flat output 9*NUM_TARGETS slot i y at [9i+8:9i]
- state_flat output 2*NUM_TARGETS 0=IDLE 1=FLYING 2=DYING
- anim_flat output 2*NUM_TARGETS 0 up, 1 mid, 2 down, 3 dead
- kill output NUM_TARGETS one-tick pulse per slot hit
- kill_count output 16 saturating total kills
- speed_level output 2 current speed level

Behaviour:
- Reset is synchronous on rst (clock clk_100Hz) and wins over all other inputs, including mid-flight or mid-fall. It clears: running=0, spawn counter=0, every slot IDLE with x_offset=INIT_X_OFFSET (x=640), y=0, anim counter=0, vy=0, kill=0, kill_count=0, speed_level=0.
- running flag: set at the edge where start&~rst is sampled (edge E0); the spawn counter is forced to 0 at E0. Start while already running is ignored.
- Spawn counter increments each edge while running.
  - At an edge where counter==SPAWN_INTERVAL-1 and an idle slot exists: counter->0; the lowest-index IDLE slot loads y=LANE_BASE+din*LANE_PITCH (9-bit), x_offset=INIT_X_OFFSET, anim counter=0, vy=0, state=FLYING.
  - First spawn: slot 0 reads FLYING after edge E0+SPAWN_INTERVAL.
  - No idle slot: counter holds at SPAWN_INTERVAL-1 and spawns on the first edge an idle slot is present.
- A slot that retires to IDLE on an edge is not spawnable until the following edge (idle state must be registered).
- FLYING, per edge:
  - If x_offset <= vfly: go IDLE. Exit wins over shot in the same edge: no kill pulse.
  - Else if shot[i]: go DYING and pulse kill[i]=1 for exactly one tick; kill_count+1, saturating at 65535.
  - Else: x_offset -= vfly; anim counter (5-bit, wraps) +1.
- DYING, per edge:
  - If y >= Y_FLOOR or x_offset <= VX_DIE: go IDLE.
  - Else: y += vy/10 (integer, vy 8-bit, pre-increment value); vy += 1, saturating at 255; x_offset -= VX_DIE.
  - shot is ignored.
- IDLE: shot is ignored.
- anim: DYING -> 3. Otherwise from anim counter[4:3]: 0->0, 1->1, 2->2, 3->1.
- Simultaneous shots on several flying slots: each gets its own kill pulse; kill_count adds the popcount in one edge, still saturating.
- vfly = VX_FLY + speed_level.
- All outputs are registered or derived combinationally from registered state only; zero-latency from state to outputs.

Optional Feature:
- TARGET_SPEEDUP_EN defined: speed_level increments (saturating at 3) each time kill_count crosses a multiple of 16. Exit threshold and decrement both use the updated vfly from the next edge.
- Not defined: speed_level is tied to 0; vfly = VX_FLY always.

Test Plan:
- rst high 3 ticks mid-game with slots flying/dying -> all state=0, x=640, y=0, kill=0, kill_count=0 after first rst edge.
- start at E0, din=2 at edge 64 -> slot0 FLYING, y=128, x=640. Stays FLYING 224 further edges (x_offset 674->2), IDLE on edge 225 after spawn.
- shot[0] while slot0 flying with y=48 -> kill[0]=1 for one tick, kill_count=1. y holds 48 for 10 dying edges, then 49; slot retires when y>=400. anim reads 3 throughout.
- Default params, no shots, run 1000 ticks -> slots 0..3 spawned at edges 64, 128, 192, 256; slot0 retires at edge 289 and respawns at edge 320; never more than 4 active.
- shot[i] on the same edge slot i has x_offset<=3 -> IDLE, no kill pulse, kill_count unchanged. Shot on an IDLE slot -> no effect.
- With TARGET_SPEEDUP_EN, 16 kills -> speed_level=1, new spawns decrement x_offset by 4/tick. Without the macro -> speed_level stays 0.
